// File: rtl/sync_sp_ram_pkg.sv
// Shared types and helpers for the banked byte-enable single-port RAM.
package sync_sp_ram_pkg;

    typedef enum logic [0:0] {
        StInit,
        StRun
    } state_e;

    // Response skid buffer entries; also the total read credit pool.
    localparam int unsigned SKID_DEPTH = 2;

    // Index width for n items, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_sp_ram_be_banked_bank.sv
// One SRAM macro model with byte-enable writes and a 1-cycle read port.
module sram_bank_be
    import sync_sp_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BANK_DEPTH = 1024,
    localparam int unsigned ROW_W     = idx_width(BANK_DEPTH),
    localparam int unsigned BE_W      = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  ce_i,
    input  logic                  we_i,
    input  logic [BE_W-1:0]       ben_i,
    input  logic [ROW_W-1:0]      addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [BANK_DEPTH];
    logic [DATA_WIDTH-1:0] bit_mask;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // Expand byte enables to a bit mask and merge with the stored word.
    always_comb begin
        for (int b = 0; b < BE_W; b++) begin
            bit_mask[b*8 +: 8] = {8{ben_i[b]}};
        end
        wr_merged = (mem_q[addr_i] & ~bit_mask) | (wdata_i & bit_mask);
    end

    // Q only changes on an enabled read; it holds otherwise.
    always_comb begin
        rdata_d = rdata_q;
        if (ce_i && !we_i) begin
            rdata_d = mem_q[addr_i];
        end
    end

    // Storage array and output latch.
    always_ff @(posedge clk_i) begin
        if (ce_i && we_i) begin
            mem_q[addr_i] <= wr_merged;
        end
        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_sp_ram_be_banked.sv
// Banked single-port byte-enable RAM with zero-init, credit-based read flow
// control and a 2-entry response skid buffer.
module sync_sp_ram_be_banked
    import sync_sp_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned ADDR_WIDTH    = 12,
    parameter int unsigned DATA_DEPTH    = 4096,
    parameter int unsigned NUM_BANKS     = 4,
    parameter int unsigned OUT_REGS      = 0,
    parameter int unsigned INIT_ON_RESET = 1
) (
    input  logic                    Clk_CI,
    input  logic                    Rst_RI,
    input  logic                    ReqValid_SI,
    output logic                    ReqReady_SO,
    input  logic                    WrEn_SI,
    input  logic [DATA_WIDTH/8-1:0] BEn_SI,
    input  logic [DATA_WIDTH-1:0]   WrData_DI,
    input  logic [ADDR_WIDTH-1:0]   Addr_DI,
    output logic                    RspValid_SO,
    input  logic                    RspReady_SI,
    output logic [DATA_WIDTH-1:0]   RdData_DO,
    output logic                    RspErr_SO,
    output logic                    InitDone_SO
);

    localparam int unsigned BANK_DEPTH = DATA_DEPTH / NUM_BANKS;
    localparam int unsigned BANK_W     = idx_width(NUM_BANKS);
    localparam int unsigned ROW_W      = idx_width(BANK_DEPTH);
    localparam int unsigned BE_W       = DATA_WIDTH / 8;
    localparam int unsigned AW1        = ADDR_WIDTH + 1;

    state_e                state_q, state_d;
    logic [ROW_W-1:0]      init_cnt_q, init_cnt_d;
    logic                  rd1_vld_q, rd1_vld_d, rd1_err_q, rd1_err_d;
    logic [BANK_W-1:0]     rd1_bank_q, rd1_bank_d;
    logic                  rd2_vld_q, rd2_vld_d, rd2_err_q, rd2_err_d;
    logic [DATA_WIDTH-1:0] rd2_data_q, rd2_data_d;
    logic [DATA_WIDTH-1:0] skid_data_q [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] skid_data_d [SKID_DEPTH];
    logic                  skid_err_q [SKID_DEPTH];
    logic                  skid_err_d [SKID_DEPTH];
    logic [0:0]            skid_wptr_q, skid_wptr_d, skid_rptr_q, skid_rptr_d;
    logic [1:0]            skid_cnt_q, skid_cnt_d;

    logic                  run, in_range, credit_ok, req_fire, rd_fire, pop;
    logic [BANK_W-1:0]     bank_sel;
    logic [ROW_W-1:0]      bank_row;
    logic [1:0]            occ;
    logic [NUM_BANKS-1:0]  bank_ce;
    logic                  bank_we;
    logic [BE_W-1:0]       bank_ben;
    logic [ROW_W-1:0]      bank_addr;
    logic [DATA_WIDTH-1:0] bank_wdata;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
    logic [DATA_WIDTH-1:0] stage1_data, push_data;
    logic                  push_vld, push_err;

    // Address decode, credit accounting and request handshake.
    always_comb begin
        run       = (state_q == StRun);
        in_range  = {1'b0, Addr_DI} < AW1'(DATA_DEPTH);
        bank_sel  = BANK_W'({1'b0, Addr_DI} / AW1'(BANK_DEPTH));
        bank_row  = ROW_W'({1'b0, Addr_DI} % AW1'(BANK_DEPTH));
        occ       = 2'(rd1_vld_q) + 2'(rd2_vld_q) + skid_cnt_q;
        credit_ok = occ < 2'(SKID_DEPTH);
        ReqReady_SO = run && (WrEn_SI || credit_ok);
        req_fire  = ReqValid_SI && ReqReady_SO && !Rst_RI;
        rd_fire   = req_fire && !WrEn_SI;
    end

    // Init walker: one zeroed row per cycle across all banks.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        unique case (state_q)
            StInit: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == ROW_W'(BANK_DEPTH - 1)) begin
                    state_d    = StRun;
                    init_cnt_d = '0;
                end
            end
            StRun: ;
        endcase
    end

    // Macro control: broadcast zero writes in init, single selected bank in run.
    always_comb begin
        bank_ce    = '0;
        bank_we    = 1'b0;
        bank_ben   = '0;
        bank_addr  = '0;
        bank_wdata = '0;
        if (!run) begin
            bank_ce   = '1;
            bank_we   = 1'b1;
            bank_ben  = '1;
            bank_addr = init_cnt_q;
        end else if (req_fire && in_range) begin
            bank_ce[bank_sel] = 1'b1;
            bank_we    = WrEn_SI;
            bank_ben   = BEn_SI;
            bank_addr  = bank_row;
            bank_wdata = WrData_DI;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        sram_bank_be #(
            .DATA_WIDTH (DATA_WIDTH),
            .BANK_DEPTH (BANK_DEPTH)
        ) u_bank (
            .clk_i   (Clk_CI),
            .ce_i    (bank_ce[b]),
            .we_i    (bank_we),
            .ben_i   (bank_ben),
            .addr_i  (bank_addr),
            .wdata_i (bank_wdata),
            .rdata_o (bank_rdata[b])
        );
    end

    // Read pipeline: macro stage, optional output register, then skid push.
    always_comb begin
        rd1_vld_d   = rd_fire;
        rd1_err_d   = rd_fire && !in_range;
        rd1_bank_d  = rd_fire ? bank_sel : rd1_bank_q;
        stage1_data = rd1_err_q ? '0 : bank_rdata[rd1_bank_q];
        rd2_vld_d   = (OUT_REGS != 0) && rd1_vld_q;
        rd2_err_d   = rd1_err_q;
        rd2_data_d  = rd1_vld_q ? stage1_data : rd2_data_q;
        if (OUT_REGS != 0) begin
            push_vld  = rd2_vld_q;
            push_data = rd2_data_q;
            push_err  = rd2_err_q;
        end else begin
            push_vld  = rd1_vld_q;
            push_data = stage1_data;
            push_err  = rd1_err_q;
        end
    end

    // Skid buffer FIFO; a credit freed by a pop shows up next cycle via occ.
    always_comb begin
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        skid_wptr_d = skid_wptr_q;
        skid_rptr_d = skid_rptr_q;
        pop         = (skid_cnt_q != 2'd0) && RspReady_SI;
        if (push_vld) begin
            skid_data_d[skid_wptr_q] = push_data;
            skid_err_d[skid_wptr_q]  = push_err;
            skid_wptr_d = skid_wptr_q + 1'b1;
        end
        if (pop) begin
            skid_rptr_d = skid_rptr_q + 1'b1;
        end
        skid_cnt_d = skid_cnt_q + 2'(push_vld) - 2'(pop);
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q     <= (INIT_ON_RESET != 0) ? StInit : StRun;
            init_cnt_q  <= '0;
            rd1_vld_q   <= 1'b0;
            rd1_err_q   <= 1'b0;
            rd1_bank_q  <= '0;
            rd2_vld_q   <= 1'b0;
            rd2_err_q   <= 1'b0;
            rd2_data_q  <= '0;
            skid_wptr_q <= '0;
            skid_rptr_q <= '0;
            skid_cnt_q  <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                skid_data_q[i] <= '0;
                skid_err_q[i]  <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            rd1_vld_q   <= rd1_vld_d;
            rd1_err_q   <= rd1_err_d;
            rd1_bank_q  <= rd1_bank_d;
            rd2_vld_q   <= rd2_vld_d;
            rd2_err_q   <= rd2_err_d;
            rd2_data_q  <= rd2_data_d;
            skid_wptr_q <= skid_wptr_d;
            skid_rptr_q <= skid_rptr_d;
            skid_cnt_q  <= skid_cnt_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
        end
    end

    // Response outputs are zero whenever nothing is presented.
    always_comb begin
        RspValid_SO = (skid_cnt_q != 2'd0);
        RdData_DO   = RspValid_SO ? skid_data_q[skid_rptr_q] : '0;
        RspErr_SO   = RspValid_SO && skid_err_q[skid_rptr_q];
        InitDone_SO = run;
    end

endmodule

// File: tb/tb_sync_sp_ram_be_banked.sv
// Scoreboard bench: a 4096-word instance (OUT_REGS=0) and a 3000-word
// instance (OUT_REGS=1) for out-of-range and latency checks.
module tb_sync_sp_ram_be_banked;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_m, rv_m, rr_m, we_m, sv_m, sr_m, er_m, dn_m;
    logic [7:0]  ben_m;
    logic [63:0] wd_m, rd_m;
    logic [11:0] a_m;
    logic        rst_o, rv_o, rr_o, we_o, sv_o, sr_o, er_o, dn_o;
    logic [7:0]  ben_o;
    logic [63:0] wd_o, rd_o;
    logic [11:0] a_o;

    sync_sp_ram_be_banked #(
        .DATA_WIDTH (64), .ADDR_WIDTH (12), .DATA_DEPTH (4096),
        .NUM_BANKS (4), .OUT_REGS (0), .INIT_ON_RESET (1)
    ) dut_main (
        .Clk_CI (clk), .Rst_RI (rst_m), .ReqValid_SI (rv_m), .ReqReady_SO (rr_m),
        .WrEn_SI (we_m), .BEn_SI (ben_m), .WrData_DI (wd_m), .Addr_DI (a_m),
        .RspValid_SO (sv_m), .RspReady_SI (sr_m), .RdData_DO (rd_m),
        .RspErr_SO (er_m), .InitDone_SO (dn_m)
    );

    sync_sp_ram_be_banked #(
        .DATA_WIDTH (64), .ADDR_WIDTH (12), .DATA_DEPTH (3000),
        .NUM_BANKS (4), .OUT_REGS (1), .INIT_ON_RESET (1)
    ) dut_oor (
        .Clk_CI (clk), .Rst_RI (rst_o), .ReqValid_SI (rv_o), .ReqReady_SO (rr_o),
        .WrEn_SI (we_o), .BEn_SI (ben_o), .WrData_DI (wd_o), .Addr_DI (a_o),
        .RspValid_SO (sv_o), .RspReady_SI (sr_o), .RdData_DO (rd_o),
        .RspErr_SO (er_o), .InitDone_SO (dn_o)
    );

    typedef struct {
        logic [63:0] data;
        logic        err;
        int unsigned acc;
        bit          lat;
    } exp_t;

    exp_t q_m[$];
    exp_t q_o[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   lat_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic mon(input bit which, input logic v, input logic r, input logic [63:0] d,
                       input logic e, input int unsigned lat);
        exp_t  x;
        string p;
        p = which ? "oor" : "main";
        if (!v) return;
        if ((which ? q_o.size() : q_m.size()) == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_unexpected_rsp: got data %h err %0b, required no response",
                     p, d, e);
            return;
        end
        x = which ? q_o[0] : q_m[0];
        if (!r) begin
            chk({p, "_hold_data"}, d, x.data);
            chk({p, "_hold_err"}, 64'(e), 64'(x.err));
            return;
        end
        if (which) x = q_o.pop_front();
        else       x = q_m.pop_front();
        chk({p, "_rsp_data"}, d, x.data);
        chk({p, "_rsp_err"}, 64'(e), 64'(x.err));
        if (x.lat) chk({p, "_rsp_latency"}, 64'(cyc - x.acc), 64'(lat));
    endtask

    always @(negedge clk) begin
        mon(1'b0, sv_m, sr_m, rd_m, er_m, 1);
        mon(1'b1, sv_o, sr_o, rd_o, er_o, 2);
    end

    task automatic drive(input bit which, input logic v, input logic we, input logic [7:0] ben,
                         input logic [63:0] wd, input logic [11:0] addr);
        if (which) begin
            rv_o = v; we_o = we; ben_o = ben; wd_o = wd; a_o = addr;
        end else begin
            rv_m = v; we_m = we; ben_m = ben; wd_m = wd; a_m = addr;
        end
    endtask

    // Issue one request (called at posedge+1); returns at posedge+1 after acceptance.
    task automatic do_req(input bit which, input logic we, input logic [7:0] ben,
                          input logic [63:0] wd, input logic [11:0] addr,
                          input logic [63:0] exp_d, input logic exp_e, input bit push);
        bit   ok;
        exp_t x;
        ok = 1'b0;
        drive(which, 1'b1, we, ben, wd, addr);
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = which ? rr_o : rr_m;
            @(posedge clk);
            #1;
        end
        drive(which, 1'b0, 1'b0, 8'h00, 64'h0, 12'h0);
        chk(which ? "oor_req_accepted" : "main_req_accepted", 64'(ok), 64'd1);
        if (ok && !we && push) begin
            x.data = exp_d; x.err = exp_e; x.acc = cyc; x.lat = lat_en;
            if (which) q_o.push_back(x);
            else       q_m.push_back(x);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Count cycles with InitDone low after release; starts at posedge+1.
    task automatic wait_init(input bit which, input int exp_cycles);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (i == 0) chk(which ? "oor_init_ready_low" : "main_init_ready_low",
                            64'(which ? rr_o : rr_m), 64'd0);
            if (which ? dn_o : dn_m) break;
            cnt++;
        end
        chk(which ? "oor_init_cycles" : "main_init_cycles", 64'(cnt), 64'(exp_cycles));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 12'h0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 64'h0, 12'h0);
        rst_m = 1'b1; rst_o = 1'b1; sr_m = 1'b1; sr_o = 1'b1;
        idle(3);
        @(negedge clk);
        chk("rst_req_ready", 64'(rr_m), 64'd0);
        chk("rst_rsp_valid", 64'(sv_m), 64'd0);
        chk("rst_rd_data", rd_m, 64'd0);
        chk("rst_rsp_err", 64'(er_m), 64'd0);
        chk("rst_init_done", 64'(dn_m), 64'd0);
        chk("rst_oor_init_done", 64'(dn_o), 64'd0);
        @(posedge clk);
        #1;
        rst_m = 1'b0; rst_o = 1'b0;
        fork
            wait_init(1'b0, 1024);
            wait_init(1'b1, 750);
        join

        // Zero-filled contents.
        do_req(1'b0, 1'b0, 8'h00, 64'h0, 12'h5A3, 64'h0, 1'b0, 1'b1);
        idle(3);

        // Byte-enable merge, read-after-write, empty mask.
        do_req(1'b0, 1'b1, 8'hFF, 64'h1122334455667788, 12'd7, 64'h0, 1'b0, 1'b0);
        do_req(1'b0, 1'b1, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 12'd7, 64'h0, 1'b0, 1'b0);
        do_req(1'b0, 1'b0, 8'h00, 64'h0, 12'd7, 64'h11223344AAAAAAAA, 1'b0, 1'b1);
        do_req(1'b0, 1'b1, 8'h00, 64'hFFFFFFFFFFFFFFFF, 12'd7, 64'h0, 1'b0, 1'b0);
        do_req(1'b0, 1'b0, 8'h00, 64'h0, 12'd7, 64'h11223344AAAAAAAA, 1'b0, 1'b1);
        idle(3);

        // One word per bank, then back-to-back reads with latency tracking.
        do_req(1'b0, 1'b1, 8'hFF, 64'hC0DE000000000000, 12'd0, 64'h0, 1'b0, 1'b0);
        do_req(1'b0, 1'b1, 8'hFF, 64'hC0DE000000000400, 12'd1024, 64'h0, 1'b0, 1'b0);
        do_req(1'b0, 1'b1, 8'hFF, 64'hC0DE000000000800, 12'd2048, 64'h0, 1'b0, 1'b0);
        do_req(1'b0, 1'b1, 8'hFF, 64'hC0DE000000000C00, 12'd3072, 64'h0, 1'b0, 1'b0);
        lat_en = 1'b1;
        do_req(1'b0, 1'b0, 8'h00, 64'h0, 12'd0, 64'hC0DE000000000000, 1'b0, 1'b1);
        do_req(1'b0, 1'b0, 8'h00, 64'h0, 12'd1024, 64'hC0DE000000000400, 1'b0, 1'b1);
        do_req(1'b0, 1'b0, 8'h00, 64'h0, 12'd2048, 64'hC0DE000000000800, 1'b0, 1'b1);
        do_req(1'b0, 1'b0, 8'h00, 64'h0, 12'd3072, 64'hC0DE000000000C00, 1'b0, 1'b1);
        lat_en = 1'b0;
        idle(4);

        // Back-pressure: two credits, writes still flow, held output, in-order drain.
        sr_m = 1'b0;
        do_req(1'b0, 1'b0, 8'h00, 64'h0, 12'd1024, 64'hC0DE000000000400, 1'b0, 1'b1);
        do_req(1'b0, 1'b0, 8'h00, 64'h0, 12'd2048, 64'hC0DE000000000800, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 64'h0, 12'd3072);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_read_blocked", 64'(rr_m), 64'd0);
        end
        @(posedge clk);
        #1;
        do_req(1'b0, 1'b1, 8'hFF, 64'h000000000000DEAD, 12'd100, 64'h0, 1'b0, 1'b0);
        idle(3);
        sr_m = 1'b1;
        do_req(1'b0, 1'b0, 8'h00, 64'h0, 12'd100, 64'h000000000000DEAD, 1'b0, 1'b1);
        do_req(1'b0, 1'b0, 8'h00, 64'h0, 12'd3072, 64'hC0DE000000000C00, 1'b0, 1'b1);
        idle(4);

        // Out-of-range handling on the 3000-word instance.
        lat_en = 1'b1;
        do_req(1'b1, 1'b0, 8'h00, 64'h0, 12'd3500, 64'h0, 1'b1, 1'b1);
        do_req(1'b1, 1'b1, 8'hFF, 64'h55550000000001F4, 12'd500, 64'h0, 1'b0, 1'b0);
        do_req(1'b1, 1'b1, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 12'd3500, 64'h0, 1'b0, 1'b0);
        do_req(1'b1, 1'b0, 8'h00, 64'h0, 12'd500, 64'h55550000000001F4, 1'b0, 1'b1);
        do_req(1'b1, 1'b1, 8'hFF, 64'h0BB70BB70BB70BB7, 12'd2999, 64'h0, 1'b0, 1'b0);
        do_req(1'b1, 1'b0, 8'h00, 64'h0, 12'd2999, 64'h0BB70BB70BB70BB7, 1'b0, 1'b1);
        do_req(1'b1, 1'b0, 8'h00, 64'h0, 12'd3000, 64'h0, 1'b1, 1'b1);
        lat_en = 1'b0;
        idle(6);
        chk("main_queue_drained", 64'(q_m.size()), 64'd0);
        chk("oor_queue_drained", 64'(q_o.size()), 64'd0);

        // In-flight read discarded by reset; then reset again mid-init.
        do_req(1'b0, 1'b0, 8'h00, 64'h0, 12'd7, 64'h0, 1'b0, 1'b0);
        rst_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_inflight_dropped", 64'(sv_m), 64'd0);
        end
        @(posedge clk);
        #1;
        rst_m = 1'b0;
        idle(500);
        rst_m = 1'b1;
        idle(1);
        rst_m = 1'b0;
        wait_init(1'b0, 1024);
        do_req(1'b0, 1'b0, 8'h00, 64'h0, 12'd7, 64'h0, 1'b0, 1'b1);
        idle(4);
        chk("final_queue_drained", 64'(q_m.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
